// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM/owner encodings and default operand widths for the FP datapath
package alu_pkg;
   localparam int ALU_DW = 24;
   localparam int ALU_RW = 23;
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   typedef logic owner_t;
   localparam owner_t OWN_MUL = 1'b0, OWN_DIV = 1'b1;
endpackage

// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: engine and CORDIC-unit signals seen by the arbiter (slave) and its environment (master)
interface cordic_arbiter_if import alu_pkg::*; #(parameter int DW = ALU_DW, parameter int RW = ALU_RW);
   logic          mul_req, mul_ack, mul_vld;
   logic [DW-1:0] mul_data1_in, mul_data2_in;
   logic          div_req, div_ack, div_vld;
   logic [DW-1:0] div_data1_in, div_data2_in;
   logic [RW-1:0] result_out;
   logic [1:0]    other_out;
   logic          err, busy;
   logic [DW-1:0] unit_data1_out, unit_data2_out;
   logic          unit_mul_trig, unit_div_trig;
   logic [RW-1:0] unit_result_in;
   logic [1:0]    unit_other_in;
   logic          unit_vld_in;
   modport slave (
      input  mul_req, mul_data1_in, mul_data2_in, div_req, div_data1_in, div_data2_in,
             unit_result_in, unit_other_in, unit_vld_in,
      output mul_ack, mul_vld, div_ack, div_vld, result_out, other_out, err,
             unit_data1_out, unit_data2_out, unit_mul_trig, unit_div_trig, busy
   );
   modport master (
      output mul_req, mul_data1_in, mul_data2_in, div_req, div_data1_in, div_data2_in,
             unit_result_in, unit_other_in, unit_vld_in,
      input  mul_ack, mul_vld, div_ack, div_vld, result_out, other_out, err,
             unit_data1_out, unit_data2_out, unit_mul_trig, unit_div_trig, busy
   );
endinterface

// File: rtl/cordic_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the engine that did not own the unit last wins
module rr_arb2 import alu_pkg::*; (
   input  logic   mul_req,
   input  logic   div_req,
   input  owner_t last_owner,
   output logic   gnt,
   output owner_t owner
);
   assign gnt   = mul_req | div_req;
   assign owner = (mul_req & div_req) ? ~last_owner : div_req ? OWN_DIV : OWN_MUL;
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC unit between the multiply and divide engines with a watchdog on the unit
module cordic_arbiter import alu_pkg::*; #(
   parameter int TIMEOUT = 64
) (
   input logic             sys_clk,
   input logic             sys_rst,
   cordic_arbiter_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT);
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   owner_t        owner, last_owner, win;
   logic          gnt;
   logic          done_now;
   rr_arb2 u_arb (
      .mul_req    (bus.mul_req),
      .div_req    (bus.div_req),
      .last_owner (last_owner),
      .gnt        (gnt),
      .owner      (win)
   );
   // a real result on the terminal count still wins over the timeout
   assign done_now = bus.unit_vld_in | (cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state              <= IDLE;
         cnt                <= '0;
         owner              <= OWN_MUL;
         last_owner         <= OWN_DIV;
         bus.mul_ack        <= 1'b0;
         bus.div_ack        <= 1'b0;
         bus.mul_vld        <= 1'b0;
         bus.div_vld        <= 1'b0;
         bus.unit_mul_trig  <= 1'b0;
         bus.unit_div_trig  <= 1'b0;
         bus.err            <= 1'b0;
         bus.busy           <= 1'b0;
         bus.result_out     <= '0;
         bus.other_out      <= '0;
         bus.unit_data1_out <= '0;
         bus.unit_data2_out <= '0;
      end else begin
         bus.mul_ack       <= 1'b0;
         bus.div_ack       <= 1'b0;
         bus.mul_vld       <= 1'b0;
         bus.div_vld       <= 1'b0;
         bus.unit_mul_trig <= 1'b0;
         bus.unit_div_trig <= 1'b0;
         bus.err           <= 1'b0;
         case (state)
            IDLE: if (gnt) begin
               state              <= ISSUE;
               owner              <= win;
               bus.busy           <= 1'b1;
               bus.unit_data1_out <= win == OWN_DIV ? bus.div_data1_in : bus.mul_data1_in;
               bus.unit_data2_out <= win == OWN_DIV ? bus.div_data2_in : bus.mul_data2_in;
               bus.mul_ack        <= win == OWN_MUL;
               bus.div_ack        <= win == OWN_DIV;
               bus.unit_mul_trig  <= win == OWN_MUL;
               bus.unit_div_trig  <= win == OWN_DIV;
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: if (done_now) begin
               state          <= DONE;
               bus.mul_vld    <= owner == OWN_MUL;
               bus.div_vld    <= owner == OWN_DIV;
               bus.err        <= ~bus.unit_vld_in;
               bus.result_out <= bus.unit_vld_in ? bus.unit_result_in : '0;
               if (bus.unit_vld_in) bus.other_out <= bus.unit_other_in;
            end else begin
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               last_owner <= owner;
               bus.busy   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed self-checking bench for the CORDIC arbiter (TIMEOUT = 64)
module tb_cordic_arbiter;
   logic sys_clk = 1'b0;
   logic sys_rst;
   int   n_asrt = 0;
   int   n_fail = 0;
   cordic_arbiter_if bus ();
   cordic_arbiter #(.TIMEOUT(64)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));
   always #5 sys_clk = ~sys_clk;
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic reply(input int lat, input logic [22:0] r, input logic [1:0] o);
      repeat (lat) step();
      bus.unit_result_in = r;
      bus.unit_other_in  = o;
      bus.unit_vld_in    = 1'b1;
      step();
      bus.unit_vld_in    = 1'b0;
   endtask
   function automatic logic [7:0] ctrl();
      return {bus.busy, bus.mul_ack, bus.div_ack, bus.mul_vld, bus.div_vld, bus.err,
              bus.unit_mul_trig, bus.unit_div_trig};
   endfunction
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      sys_rst = 1'b1;
      bus.mul_req = 1'b0; bus.div_req = 1'b0; bus.unit_vld_in = 1'b0;
      bus.mul_data1_in = '0; bus.mul_data2_in = '0;
      bus.div_data1_in = '0; bus.div_data2_in = '0;
      bus.unit_result_in = '0; bus.unit_other_in = '0;
      step(); step();
      chk("rst_ctrl", ctrl(), 8'h00);
      chk("rst_res", {bus.result_out, bus.other_out}, 0);
      chk("rst_data", {bus.unit_data1_out, bus.unit_data2_out}, 0);
      sys_rst = 1'b0;
      // single multiply request
      bus.mul_req = 1'b1; bus.mul_data1_in = 24'h800000; bus.mul_data2_in = 24'hC00000;
      step();
      chk("t1_ack", ctrl(), 8'b1100_0010);
      chk("t1_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'h800000, 24'hC00000});
      bus.mul_req = 1'b0;
      reply(10, 23'h400000, 2'b01);
      chk("t1_vld", ctrl(), 8'b1001_0000);
      chk("t1_res", {bus.result_out, bus.other_out}, {23'h400000, 2'b01});
      step();
      chk("t1_idle", ctrl(), 8'h00);
      chk("t1_hold", bus.result_out, 23'h400000);
      // divide request, unit never answers
      bus.div_req = 1'b1; bus.div_data1_in = 24'hABCDEF; bus.div_data2_in = 24'h123456;
      step();
      chk("to_ack", ctrl(), 8'b1010_0001);
      bus.div_req = 1'b0;
      repeat (64) step();
      chk("to_early", ctrl(), 8'b1000_0000);
      step();
      chk("to_vld", ctrl(), 8'b1000_1100);
      chk("to_res", bus.result_out, 0);
      chk("to_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'hABCDEF, 24'h123456});
      step();
      chk("to_busy", ctrl(), 8'h00);
      // simultaneous requests alternate
      bus.mul_data1_in = 24'h111111; bus.mul_data2_in = 24'h222222;
      bus.div_data1_in = 24'h333333; bus.div_data2_in = 24'h444444;
      bus.mul_req = 1'b1; bus.div_req = 1'b1;
      step();
      chk("rr1_ack", {bus.mul_ack, bus.div_ack}, 2'b10);
      chk("rr1_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'h111111, 24'h222222});
      bus.mul_req = 1'b0;
      reply(2, 23'h0AAAAA, 2'b10);
      chk("rr1_vld", {bus.mul_vld, bus.div_vld, bus.result_out}, {2'b10, 23'h0AAAAA});
      bus.mul_req = 1'b1;
      step(); step();
      chk("rr2_ack", {bus.mul_ack, bus.div_ack}, 2'b01);
      chk("rr2_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'h333333, 24'h444444});
      bus.div_req = 1'b0;
      reply(1, 23'h055555, 2'b11);
      chk("rr2_vld", {bus.mul_vld, bus.div_vld, bus.result_out}, {2'b01, 23'h055555});
      bus.div_req = 1'b1;
      step(); step();
      chk("rr3_ack", {bus.mul_ack, bus.div_ack}, 2'b10);
      chk("rr3_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'h111111, 24'h222222});
      bus.mul_req = 1'b0;
      reply(1, 23'h0CCCCC, 2'b00);
      chk("rr3_vld", {bus.mul_vld, bus.div_vld}, 2'b10);
      step(); step();
      chk("rr4_ack", {bus.mul_ack, bus.div_ack}, 2'b01);
      chk("rr4_ops", {bus.unit_data1_out, bus.unit_data2_out}, {24'h333333, 24'h444444});
      bus.div_req = 1'b0;
      reply(1, 23'h0F0F0F, 2'b01);
      chk("rr4_vld", {bus.mul_vld, bus.div_vld, bus.result_out}, {2'b01, 23'h0F0F0F});
      step();
      // spurious unit valids in IDLE and ISSUE
      bus.unit_result_in = 23'h7FFFFF; bus.unit_vld_in = 1'b1;
      step();
      chk("sp_idle", ctrl(), 8'h00);
      chk("sp_idle_res", bus.result_out, 23'h0F0F0F);
      bus.unit_vld_in = 1'b0;
      bus.mul_req = 1'b1;
      step();
      chk("sp_ack", ctrl(), 8'b1100_0010);
      bus.mul_req = 1'b0; bus.unit_vld_in = 1'b1;
      step();
      chk("sp_issue", ctrl(), 8'b1000_0000);
      bus.unit_vld_in = 1'b0;
      reply(2, 23'h123456, 2'b00);
      chk("sp_vld", ctrl(), 8'b1001_0000);
      chk("sp_res", bus.result_out, 23'h123456);
      step();
      // reset while waiting on the unit
      bus.div_req = 1'b1;
      step();
      bus.div_req = 1'b0;
      step(); step();
      sys_rst = 1'b1;
      step();
      chk("mr_ctrl", ctrl(), 8'h00);
      chk("mr_res", {bus.result_out, bus.other_out}, 0);
      chk("mr_data", {bus.unit_data1_out, bus.unit_data2_out}, 0);
      sys_rst = 1'b0; bus.unit_vld_in = 1'b1;
      step();
      chk("mr_late", ctrl(), 8'h00);
      bus.unit_vld_in = 1'b0;
      bus.mul_req = 1'b1; bus.div_req = 1'b1;
      step();
      chk("mr_prio", {bus.mul_ack, bus.div_ack}, 2'b10);
      bus.mul_req = 1'b0;
      reply(1, 23'h000001, 2'b00);
      chk("mr_mvld", {bus.mul_vld, bus.div_vld}, 2'b10);
      step(); step();
      chk("mr_dack", {bus.mul_ack, bus.div_ack}, 2'b01);
      bus.div_req = 1'b0;
      reply(1, 23'h000002, 2'b00);
      chk("mr_dvld", {bus.mul_vld, bus.div_vld, bus.result_out}, {2'b01, 23'h000002});
      step();
      // valid arrives on the terminal count
      bus.mul_req = 1'b1;
      step();
      bus.mul_req = 1'b0;
      reply(64, 23'h3C3C3C, 2'b10);
      chk("tc_vld", ctrl(), 8'b1001_0000);
      chk("tc_res", {bus.result_out, bus.other_out}, {23'h3C3C3C, 2'b10});
      step();
      chk("tc_idle", ctrl(), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
